// File: rtl/j1_io_bank_if.sv
// j1 io bus: strobes, one-hot address, write data and read-back data.
// The core drives the master side, the io bank is the slave.
interface j1_io_bank_if #(
  parameter int WIDTH = 32
);
  logic             io_rd;
  logic             io_wr;
  logic [15:0]      io_addr;
  logic [WIDTH-1:0] io_dout;
  logic [WIDTH-1:0] io_din;

  modport master (
    output io_rd, io_wr, io_addr, io_dout,
    input  io_din
  );

  modport slave (
    input  io_rd, io_wr, io_addr, io_dout,
    output io_din
  );
endinterface

// File: rtl/j1_io_bank.sv
// j1 io bank: GPIO ports, ticks timer with overflow irq, UART TX glue
// and a UART RX FIFO, all decoded from the one-hot io_addr bus.
module j1_io_bank #(
  parameter int WIDTH   = 32,
  parameter int NPORTS  = 3,
  parameter int RXDEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  j1_io_bank_if.slave              bus,
  output logic                     interrupt_request,
  output logic                     uart_tx_wr,
  output logic [7:0]               uart_tx_data,
  input  logic                     uart_tx_busy,
  input  logic                     uart_rx_valid,
  input  logic [7:0]               uart_rx_data,
  input  logic [NPORTS*WIDTH-1:0]  gpio_in,
  output logic [NPORTS*WIDTH-1:0]  gpio_out,
  output logic [NPORTS*WIDTH-1:0]  gpio_oe
);

  localparam int AW = $clog2(RXDEPTH);
  localparam int CW = AW + 1;
  localparam int PW = NPORTS * WIDTH;

  logic [PW-1:0]    r_sync1;
  logic [PW-1:0]    r_sync2;
  logic [PW-1:0]    r_out;
  logic [PW-1:0]    r_oe;
  logic [WIDTH-1:0] r_ticks;
  logic             r_irq_pend;
  logic             r_irq;
  logic [7:0]       r_mem [RXDEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_count;
  logic             r_ovf;

  logic             w_ld_ticks;
  logic             w_wrap;
  logic             w_irq_ack;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_ovf_clr;
  logic [WIDTH-1:0] w_din;
  logic             w_unused_addr;

  assign w_ld_ticks = bus.io_wr & bus.io_addr[14];
  assign w_wrap     = !w_ld_ticks && (&r_ticks);
  assign w_irq_ack  = bus.io_wr & bus.io_addr[15]
                    & bus.io_dout[0];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(RXDEPTH));
  assign w_pop      = bus.io_rd & bus.io_addr[12] & !w_empty;
  // A pop frees the slot, so a push into a full FIFO still lands.
  assign w_push     = uart_rx_valid & (!w_full | w_pop);
  assign w_drop     = uart_rx_valid & w_full & !w_pop;
  assign w_ovf_clr  = bus.io_wr & bus.io_addr[13]
                    & bus.io_dout[2];
  assign w_unused_addr = ^bus.io_addr;

  assign uart_tx_wr   = bus.io_wr & bus.io_addr[12];
  assign uart_tx_data = bus.io_dout[7:0];
  assign gpio_out     = r_out;
  assign gpio_oe      = r_oe;
  assign interrupt_request = r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_out   <= '0;
      r_oe    <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      for (int k = 0; k < NPORTS; k++) begin
        if (bus.io_wr && bus.io_addr[4*k+1])
          r_out[k*WIDTH +: WIDTH] <= bus.io_dout;
        if (bus.io_wr && bus.io_addr[4*k+2])
          r_oe[k*WIDTH +: WIDTH] <= bus.io_dout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ticks    <= '0;
      r_irq      <= 1'b0;
      r_irq_pend <= 1'b0;
    end else begin
      r_ticks <= w_ld_ticks ? bus.io_dout
                            : r_ticks + WIDTH'(1);
      r_irq   <= w_wrap;
      if (w_wrap)
        r_irq_pend <= 1'b1;
      else if (w_irq_ack)
        r_irq_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push)
        r_wp <= r_wp + AW'(1);
      if (w_pop)
        r_rp <= r_rp + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_drop)
        r_ovf <= 1'b1;
      else if (w_ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wp] <= uart_rx_data;
  end

  always_comb begin
    w_din = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (bus.io_addr[4*k])
        w_din = w_din | r_sync2[k*WIDTH +: WIDTH];
      if (bus.io_addr[4*k+1])
        w_din = w_din | r_out[k*WIDTH +: WIDTH];
      if (bus.io_addr[4*k+2])
        w_din = w_din | r_oe[k*WIDTH +: WIDTH];
    end
    if (bus.io_addr[12] && !w_empty)
      w_din = w_din | {{(WIDTH-8){1'b0}}, r_mem[r_rp]};
    if (bus.io_addr[13])
      w_din = w_din | {{(WIDTH-4){1'b0}}, r_irq_pend,
                       r_ovf, !w_empty, !uart_tx_busy};
    if (bus.io_addr[14])
      w_din = w_din | r_ticks;
    if (bus.io_addr[15])
      w_din = w_din | {{(WIDTH-1){1'b0}}, r_irq_pend};
  end

  assign bus.io_din = w_din;

endmodule

// File: tb/tb_j1_io_bank.sv
// Randomised self-checking bench for j1_io_bank against a queue/array
// model of the io map, timer interrupt and RX FIFO.
module tb_j1_io_bank;
  localparam int W  = 32;
  localparam int NP = 3;
  localparam int RD = 8;

  logic clk = 1'b0;
  logic reset;
  logic interrupt_request, uart_tx_wr, uart_tx_busy;
  logic uart_rx_valid;
  logic [7:0] uart_tx_data, uart_rx_data;
  logic [NP*W-1:0] gpio_in, gpio_out, gpio_oe;

  always #5 clk = ~clk;

  j1_io_bank_if #(.WIDTH(W)) bus ();

  j1_io_bank #(.WIDTH(W), .NPORTS(NP), .RXDEPTH(RD)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .interrupt_request(interrupt_request),
    .uart_tx_wr(uart_tx_wr), .uart_tx_data(uart_tx_data),
    .uart_tx_busy(uart_tx_busy),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   q [$];
  bit           m_ovf, m_irq;
  logic [W-1:0] m_out [NP];
  logic [W-1:0] m_oe  [NP];

  function automatic logic [W-1:0] misc_exp();
    return {28'b0, m_irq, m_ovf, q.size() != 0, !uart_tx_busy};
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_irq = 0;
    for (int k = 0; k < NP; k++) begin
      m_out[k] = '0;
      m_oe[k]  = '0;
    end
  endtask

  task automatic idle();
    bus.io_rd = 0; bus.io_wr = 0;
    bus.io_addr = '0; bus.io_dout = '0;
    uart_rx_valid = 0; uart_rx_data = '0;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [W-1:0] d);
    bus.io_wr = 1; bus.io_addr = a; bus.io_dout = d;
    @(negedge clk);
    bus.io_wr = 0; bus.io_addr = '0; bus.io_dout = '0;
  endtask

  task automatic io_read(input logic [15:0] a, output logic [W-1:0] d);
    bus.io_rd = 1; bus.io_addr = a;
    #1 d = bus.io_din;
    @(negedge clk);
    bus.io_rd = 0; bus.io_addr = '0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    uart_rx_valid = 1; uart_rx_data = b;
    @(negedge clk);
    uart_rx_valid = 0;
    if (q.size() < RD) q.push_back(b);
    else m_ovf = 1;
  endtask

  task automatic test_reset();
    logic [W-1:0] v;
    reset = 1; idle(); uart_tx_busy = 0; gpio_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (gpio_out !== '0) $display("FAIL rst_gpio_out got %h exp 0", gpio_out);
    else n_pass++;
    n_checks++;
    if (gpio_oe !== '0) $display("FAIL rst_gpio_oe got %h exp 0", gpio_oe);
    else n_pass++;
    n_checks++;
    if (interrupt_request !== 1'b0) $display("FAIL rst_irq got %b exp 0", interrupt_request);
    else n_pass++;
    reset = 0;
    io_read(16'h4000, v);
    n_checks++;
    if (v !== '0) $display("FAIL rst_ticks got %h exp 0", v);
    else n_pass++;
    io_read(16'h2000, v);
    n_checks++;
    if (v !== 32'h1) $display("FAIL rst_misc got %h exp 1", v);
    else n_pass++;
    io_read(16'h0002, v);
    n_checks++;
    if (v !== '0) $display("FAIL rst_out0 got %h exp 0", v);
    else n_pass++;
    io_read(16'h0004, v);
    n_checks++;
    if (v !== '0) $display("FAIL rst_dir0 got %h exp 0", v);
    else n_pass++;
  endtask

  task automatic test_gpio();
    logic [W-1:0] v, d, e, old;
    logic [15:0] a;
    int k;
    for (int p = 0; p < NP; p++) begin
      d = (p == 0) ? 32'hA5A5A5A5 : $urandom;
      a = 16'(1) << (4*p+1);
      io_write(a, d); m_out[p] = d;
      n_checks++;
      if (gpio_out[p*W +: W] !== d) $display("FAIL gpio_out[%0d] got %h exp %h", p, gpio_out[p*W +: W], d);
      else n_pass++;
      d = (p == 0) ? 32'hFFFF0000 : $urandom;
      a = 16'(1) << (4*p+2);
      io_write(a, d); m_oe[p] = d;
      n_checks++;
      if (gpio_oe[p*W +: W] !== d) $display("FAIL gpio_oe[%0d] got %h exp %h", p, gpio_oe[p*W +: W], d);
      else n_pass++;
    end
    io_read(16'h0222, v);
    e = m_out[0] | m_out[1] | m_out[2];
    n_checks++;
    if (v !== e) $display("FAIL gpio_or_read got %h exp %h", v, e);
    else n_pass++;
    d = $urandom;
    io_write(16'h0006, d); m_out[0] = d; m_oe[0] = d;
    n_checks++;
    if (gpio_out[W-1:0] !== d || gpio_oe[W-1:0] !== d)
      $display("FAIL gpio_multi got %h/%h exp %h", gpio_out[W-1:0], gpio_oe[W-1:0], d);
    else n_pass++;
    io_read(16'h0440, v);
    e = m_oe[1] | m_oe[2];
    n_checks++;
    if (v !== e) $display("FAIL gpio_dir_read got %h exp %h", v, e);
    else n_pass++;
    for (int t = 0; t < 4; t++) begin
      k = (t == 0) ? 0 : int'($urandom_range(0, NP-1));
      d = (t == 0) ? 32'h12345678 : $urandom;
      old = gpio_in[k*W +: W];
      gpio_in[k*W +: W] = d;
      a = 16'(1) << (4*k);
      for (int c = 0; c < 3; c++) begin
        io_read(a, v);
        e = (c < 2) ? old : d;
        n_checks++;
        if (v !== e) $display("FAIL gpio_sync[%0d] c%0d got %h exp %h", k, c, v, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_ticks();
    logic [W-1:0] v, ld, e;
    int n;
    for (int t = 0; t < 4; t++) begin
      ld = $urandom_range(0, 32'h7FFFFFFF);
      io_write(16'h4000, ld);
      io_read(16'h4000, v);
      n_checks++;
      if (v !== ld) $display("FAIL ticks_load got %h exp %h", v, ld);
      else n_pass++;
      n = $urandom_range(0, 20);
      repeat (n) @(negedge clk);
      io_read(16'h4000, v);
      e = ld + 32'(n) + 1;
      n_checks++;
      if (v !== e) $display("FAIL ticks_count got %h exp %h", v, e);
      else n_pass++;
    end
  endtask

  task automatic test_irq();
    logic [W-1:0] v;
    logic [5:0] hits;
    hits = '0;
    io_write(16'h4000, 32'hFFFFFFFD);
    for (int i = 0; i < 6; i++) begin
      hits[i] = interrupt_request;
      @(negedge clk);
    end
    m_irq = 1;
    n_checks++;
    if (hits !== 6'b001000) $display("FAIL irq_pulse got %b exp 001000", hits);
    else n_pass++;
    io_read(16'h8000, v);
    n_checks++;
    if (v !== 32'h1) $display("FAIL irq_pending got %h exp 1", v);
    else n_pass++;
    io_read(16'h2000, v);
    n_checks++;
    if (v !== misc_exp()) $display("FAIL irq_misc got %h exp %h", v, misc_exp());
    else n_pass++;
    io_write(16'h8000, 32'h0);
    io_read(16'h8000, v);
    n_checks++;
    if (v !== 32'h1) $display("FAIL irq_noack got %h exp 1", v);
    else n_pass++;
    io_write(16'h8000, 32'h1); m_irq = 0;
    io_read(16'h8000, v);
    n_checks++;
    if (v !== 32'h0) $display("FAIL irq_ack got %h exp 0", v);
    else n_pass++;
    io_write(16'h4000, 32'hFFFFFFFD);
    repeat (2) @(negedge clk);
    io_write(16'h8000, 32'h1); m_irq = 1;
    io_read(16'h8000, v);
    n_checks++;
    if (v !== 32'h1) $display("FAIL irq_race got %h exp 1", v);
    else n_pass++;
    io_write(16'h8000, 32'h1); m_irq = 0;
    io_read(16'h8000, v);
    n_checks++;
    if (v !== 32'h0) $display("FAIL irq_ack2 got %h exp 0", v);
    else n_pass++;
  endtask

  task automatic test_fifo();
    logic [W-1:0] v, e;
    for (int t = 0; t < 3; t++) begin
      uart_tx_busy = 1'($urandom);
      for (int i = 0; i < 3; i++)
        rx_push((t == 0) ? 8'(8'h41 + i) : 8'($urandom));
      io_read(16'h2000, v);
      n_checks++;
      if (v !== misc_exp()) $display("FAIL fifo_misc_full got %h exp %h", v, misc_exp());
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
        e = (q.size() != 0) ? W'(q[0]) : '0;
        io_read(16'h1000, v);
        if (q.size() != 0) void'(q.pop_front());
        n_checks++;
        if (v !== e) $display("FAIL fifo_pop%0d got %h exp %h", i, v, e);
        else n_pass++;
      end
      io_read(16'h2000, v);
      n_checks++;
      if (v !== misc_exp()) $display("FAIL fifo_misc_empty got %h exp %h", v, misc_exp());
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] v, e;
    logic [7:0] b;
    uart_tx_busy = 0;
    for (int i = 0; i < RD + 1; i++) rx_push(8'($urandom));
    io_read(16'h2000, v);
    n_checks++;
    if (v !== misc_exp()) $display("FAIL ovf_misc got %h exp %h", v, misc_exp());
    else n_pass++;
    b = 8'($urandom);
    uart_rx_valid = 1; uart_rx_data = b;
    bus.io_rd = 1; bus.io_addr = 16'h1000;
    #1 v = bus.io_din;
    e = W'(q[0]);
    @(negedge clk);
    idle();
    void'(q.pop_front()); q.push_back(b);
    n_checks++;
    if (v !== e) $display("FAIL full_pushpop got %h exp %h", v, e);
    else n_pass++;
    io_read(16'h2000, v);
    n_checks++;
    if (v !== misc_exp()) $display("FAIL full_pushpop_misc got %h exp %h", v, misc_exp());
    else n_pass++;
    io_write(16'h2000, 32'h4); m_ovf = 0;
    io_read(16'h2000, v);
    n_checks++;
    if (v !== misc_exp()) $display("FAIL ovf_clear got %h exp %h", v, misc_exp());
    else n_pass++;
    for (int i = 0; i < RD + 1; i++) begin
      e = (q.size() != 0) ? W'(q[0]) : '0;
      io_read(16'h1000, v);
      if (q.size() != 0) void'(q.pop_front());
      n_checks++;
      if (v !== e) $display("FAIL ovf_drain%0d got %h exp %h", i, v, e);
      else n_pass++;
    end
    b = 8'($urandom);
    uart_rx_valid = 1; uart_rx_data = b;
    bus.io_rd = 1; bus.io_addr = 16'h1000;
    #1 v = bus.io_din;
    @(negedge clk);
    idle();
    q.push_back(b);
    n_checks++;
    if (v !== '0) $display("FAIL empty_pushpop got %h exp 0", v);
    else n_pass++;
    e = W'(q.pop_front());
    io_read(16'h1000, v);
    n_checks++;
    if (v !== e) $display("FAIL empty_pushpop_data got %h exp %h", v, e);
    else n_pass++;
  endtask

  task automatic test_tx();
    logic [W-1:0] d, v;
    for (int t = 0; t < 3; t++) begin
      d = (t == 0) ? 32'h155 : $urandom;
      bus.io_wr = 1; bus.io_addr = 16'h1000; bus.io_dout = d;
      #1;
      n_checks++;
      if (uart_tx_wr !== 1'b1 || uart_tx_data !== d[7:0])
        $display("FAIL tx_strobe got %b/%h exp 1/%h", uart_tx_wr, uart_tx_data, d[7:0]);
      else n_pass++;
      @(negedge clk);
      idle();
      #1;
      n_checks++;
      if (uart_tx_wr !== 1'b0) $display("FAIL tx_pulse_end got %b exp 0", uart_tx_wr);
      else n_pass++;
    end
    @(negedge clk);
    io_read(16'h2000, v);
    n_checks++;
    if (v !== misc_exp()) $display("FAIL tx_no_push got %h exp %h", v, misc_exp());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] v;
    for (int i = 0; i < 3; i++) rx_push(8'($urandom));
    io_write(16'h0022, $urandom);
    io_write(16'h4000, 32'hFFFFFFFF);
    @(negedge clk);
    n_checks++;
    if (interrupt_request !== 1'b1) $display("FAIL pre_rst_irq got %b exp 1", interrupt_request);
    else n_pass++;
    io_write(16'h4000, 32'hFFFFFFFF);
    reset = 1;
    uart_rx_valid = 1; uart_rx_data = 8'($urandom);
    bus.io_wr = 1; bus.io_addr = 16'h0006; bus.io_dout = $urandom;
    @(negedge clk);
    idle();
    model_reset();
    n_checks++;
    if (gpio_out !== '0 || gpio_oe !== '0)
      $display("FAIL mid_rst_gpio got %h/%h exp 0", gpio_out, gpio_oe);
    else n_pass++;
    n_checks++;
    if (interrupt_request !== 1'b0) $display("FAIL mid_rst_irq got %b exp 0", interrupt_request);
    else n_pass++;
    bus.io_addr = 16'h1000; #1 v = bus.io_din;
    n_checks++;
    if (v !== '0) $display("FAIL mid_rst_fifo got %h exp 0", v);
    else n_pass++;
    bus.io_addr = 16'h2000; #1 v = bus.io_din;
    n_checks++;
    if (v !== misc_exp()) $display("FAIL mid_rst_misc got %h exp %h", v, misc_exp());
    else n_pass++;
    bus.io_addr = 16'hC000; #1 v = bus.io_din;
    n_checks++;
    if (v !== '0) $display("FAIL mid_rst_ticks got %h exp 0", v);
    else n_pass++;
    bus.io_addr = 16'h0111; #1 v = bus.io_din;
    n_checks++;
    if (v !== '0) $display("FAIL mid_rst_sync got %h exp 0", v);
    else n_pass++;
    bus.io_addr = '0;
    @(negedge clk);
    reset = 0;
    io_read(16'h1000, v);
    n_checks++;
    if (v !== '0) $display("FAIL post_rst_fifo got %h exp 0", v);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_gpio();
    test_ticks();
    test_irq();
    test_fifo();
    test_overflow();
    test_tx();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, exp finish");
    $fatal(1, "timeout");
  end

endmodule
